// File: rtl/dbg_commit_queue.sv
// dbg_commit_queue: in-order retire-record FIFO replaying one record per cycle to the Dbg block.
module dbg_commit_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [31:0]      wb_pc,
  input  logic [31:0]      wb_inst,
  input  logic             wb_gpr_wen,
  input  logic [4:0]       wb_gpr_waddr,
  input  logic [31:0]      wb_gpr_wdata,
  input  logic             wb_csr_wen,
  input  logic [11:0]      wb_csr_waddr,
  input  logic [31:0]      wb_csr_wdata,
  input  logic             wb_brk,
  input  logic             wb_ivd,
  input  logic             dbg_stall,
  output logic [31:0]      pc,
  output logic [31:0]      inst,
  output logic             done,
  output logic             gpr_wen,
  output logic [31:0]      gpr_waddr,
  output logic [31:0]      gpr_wdata,
  output logic             csr_wen,
  output logic [31:0]      csr_waddr,
  output logic [31:0]      csr_wdata,
  output logic             brk,
  output logic             ivd,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        brk;
    logic        ivd;
  } rec_t;
  rec_t        mem [DEPTH];
  rec_t        head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = wr_ptr == rd_ptr;
  assign wb_ready = !full && !halted;
  assign push     = wb_valid && wb_ready;
  assign pop      = !empty && !dbg_stall;
  assign head     = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push)
      mem[wr_ptr[AW-1:0]] <= '{wb_pc, wb_inst, wb_gpr_wen, wb_gpr_waddr, wb_gpr_wdata,
                               wb_csr_wen, wb_csr_waddr, wb_csr_wdata, wb_brk, wb_ivd};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      halted <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + (AW+1)'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
      halted <= halted || (push && (wb_brk || wb_ivd));
    end
  end
  // Strobed flags are pulsed per pop; payload fields hold until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      inst       <= '0;
      done       <= 1'b0;
      gpr_wen    <= 1'b0;
      gpr_waddr  <= '0;
      gpr_wdata  <= '0;
      csr_wen    <= 1'b0;
      csr_waddr  <= '0;
      csr_wdata  <= '0;
      brk        <= 1'b0;
      ivd        <= 1'b0;
      retire_cnt <= '0;
    end else begin
      done    <= pop;
      gpr_wen <= pop && head.gpr_wen && (head.gpr_waddr != 5'd0);
      csr_wen <= pop && head.csr_wen;
      brk     <= pop && head.brk;
      ivd     <= pop && head.ivd;
      if (pop) begin
        pc         <= head.pc;
        inst       <= head.inst;
        gpr_waddr  <= {27'd0, head.gpr_waddr};
        gpr_wdata  <= head.gpr_wdata;
        csr_waddr  <= {20'd0, head.csr_waddr};
        csr_wdata  <= head.csr_wdata;
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_dbg_commit_queue.sv
// tb_dbg_commit_queue: vector table, directed sequences and random traffic against a queue model.
module tb_dbg_commit_queue;
  localparam logic [31:0] RESET_PC = 32'h80000000;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, wb_valid = 0, dbg_stall = 0;
  logic wb_ready, wb_gpr_wen = 0, wb_csr_wen = 0, wb_brk = 0, wb_ivd = 0;
  logic [31:0] wb_pc = 0, wb_inst = 0, wb_gpr_wdata = 0, wb_csr_wdata = 0;
  logic [4:0] wb_gpr_waddr = 0;
  logic [11:0] wb_csr_waddr = 0;
  logic [31:0] pc, inst, gpr_waddr, gpr_wdata, csr_waddr, csr_wdata;
  logic done, gpr_wen, csr_wen, brk, ivd, halted;
  logic [63:0] retire_cnt;
  always #5 clk = ~clk;
  dbg_commit_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
    .wb_inst(wb_inst), .wb_gpr_wen(wb_gpr_wen), .wb_gpr_waddr(wb_gpr_waddr),
    .wb_gpr_wdata(wb_gpr_wdata), .wb_csr_wen(wb_csr_wen), .wb_csr_waddr(wb_csr_waddr),
    .wb_csr_wdata(wb_csr_wdata), .wb_brk(wb_brk), .wb_ivd(wb_ivd), .dbg_stall(dbg_stall),
    .pc(pc), .inst(inst), .done(done), .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .brk(brk), .ivd(ivd), .halted(halted), .retire_cnt(retire_cnt));
  typedef struct packed {
    logic [31:0] pc, inst;
    logic gwen; logic [4:0] gaddr; logic [31:0] gdata;
    logic cwen; logic [11:0] caddr; logic [31:0] cdata;
    logic brk, ivd;
  } rec_t;
  typedef struct {
    rec_t r;
    logic e_gwen; logic [31:0] e_gaddr, e_gdata;
    logic e_cwen; logic [31:0] e_caddr;
  } vec_t;
  typedef struct { logic [31:0] pc; logic gwen; logic [31:0] gaddr; logic cwen; logic [31:0] caddr; logic brk; } sl_t;
  int n_cmp = 0, n_bad = 0;
  rec_t mq[$];
  sl_t dlog[$];
  bit last_push;
  logic [31:0] m_pc = RESET_PC, m_inst = 0, m_gaddr = 0, m_gdata = 0, m_caddr = 0, m_cdata = 0;
  logic m_done = 0, m_gwen = 0, m_cwen = 0, m_brk = 0, m_ivd = 0, m_halted = 0;
  logic [63:0] m_cnt = 0;
  function automatic bit m_ready();
    return !m_halted && mq.size() < DEPTH;
  endfunction
  function automatic logic [319:0] dut_vec();
    return {pc, inst, done, gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata,
            brk, ivd, halted, wb_ready, retire_cnt};
  endfunction
  function automatic logic [319:0] mdl_vec();
    return {m_pc, m_inst, m_done, m_gwen, m_gaddr, m_gdata, m_cwen, m_caddr, m_cdata,
            m_brk, m_ivd, m_halted, m_ready(), m_cnt};
  endfunction
  task automatic chk(input string n, input logic [319:0] a, input logic [319:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(input rec_t r);
    {wb_pc, wb_inst, wb_gpr_wen, wb_gpr_waddr, wb_gpr_wdata, wb_csr_wen, wb_csr_waddr,
     wb_csr_wdata, wb_brk, wb_ivd} = r;
  endtask
  // Advance one clock; the model pops the front record if allowed, then appends an accepted push.
  task automatic tick();
    bit pop, push;
    rec_t r, f;
    pop = !reset && mq.size() > 0 && !dbg_stall;
    push = !reset && wb_valid && m_ready();
    r = {wb_pc, wb_inst, wb_gpr_wen, wb_gpr_waddr, wb_gpr_wdata, wb_csr_wen, wb_csr_waddr,
         wb_csr_wdata, wb_brk, wb_ivd};
    last_push = push;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      {m_inst, m_gaddr, m_gdata, m_caddr, m_cdata} = '0;
      {m_done, m_gwen, m_cwen, m_brk, m_ivd, m_halted} = '0;
      m_pc = RESET_PC;
      m_cnt = 0;
    end else begin
      {m_done, m_gwen, m_cwen, m_brk, m_ivd} = '0;
      if (pop) begin
        f = mq.pop_front();
        m_done = 1;
        m_pc = f.pc; m_inst = f.inst;
        m_gwen = f.gwen && f.gaddr != 0; m_gaddr = 32'(f.gaddr); m_gdata = f.gdata;
        m_cwen = f.cwen; m_caddr = 32'(f.caddr); m_cdata = f.cdata;
        m_brk = f.brk; m_ivd = f.ivd;
        m_cnt++;
      end
      if (push) begin
        mq.push_back(r);
        if (r.brk || r.ivd) m_halted = 1;
      end
    end
    #1;
    chk("cycle", dut_vec(), mdl_vec());
    if (done) dlog.push_back('{pc, gpr_wen, gpr_waddr, csr_wen, csr_waddr, brk});
  endtask
  task automatic do_reset();
    reset = 1; wb_valid = 0; dbg_stall = 0;
    tick();
    reset = 0;
    dlog.delete();
  endtask
  function automatic rec_t mk(input logic [31:0] p);
    rec_t r = '0;
    r.pc = p; r.inst = 32'h00000013;
    return r;
  endfunction
  vec_t tbl[4];
  initial begin
    rec_t r;
    int k;
    tbl[0].r = mk(32'h80000000); tbl[0].r.inst = 32'h00100093;
    tbl[0].r.gwen = 1; tbl[0].r.gaddr = 1; tbl[0].r.gdata = 1;
    tbl[0].e_gwen = 1; tbl[0].e_gaddr = 1; tbl[0].e_gdata = 1; tbl[0].e_cwen = 0; tbl[0].e_caddr = 0;
    tbl[1].r = mk(32'h80000010); tbl[1].r.gwen = 1; tbl[1].r.gaddr = 0; tbl[1].r.gdata = 32'hdeadbeef;
    tbl[1].e_gwen = 0; tbl[1].e_gaddr = 0; tbl[1].e_gdata = 32'hdeadbeef; tbl[1].e_cwen = 0; tbl[1].e_caddr = 0;
    tbl[2].r = mk(32'h80000004); tbl[2].r.cwen = 1; tbl[2].r.caddr = 12'h300; tbl[2].r.cdata = 32'h1800;
    tbl[2].e_gwen = 0; tbl[2].e_gaddr = 0; tbl[2].e_gdata = 0; tbl[2].e_cwen = 1; tbl[2].e_caddr = 32'h300;
    tbl[3].r = mk(32'h80000020); tbl[3].r.gwen = 1; tbl[3].r.gaddr = 31; tbl[3].r.gdata = 32'h5a5a5a5a;
    tbl[3].r.caddr = 12'hfff;
    tbl[3].e_gwen = 1; tbl[3].e_gaddr = 31; tbl[3].e_gdata = 32'h5a5a5a5a; tbl[3].e_cwen = 0; tbl[3].e_caddr = 32'hfff;
    do_reset();
    chk("reset_pc", 320'(pc), 320'(RESET_PC));
    chk("reset_state", 320'({done, halted, wb_ready, retire_cnt}), 320'({3'b001, 64'd0}));
    // Table: push into an empty queue, strobe expected two cycles later.
    foreach (tbl[i]) begin
      do_reset();
      drive(tbl[i].r); wb_valid = 1;
      tick();
      wb_valid = 0;
      chk("tbl_nodone_n1", 320'(done), 320'(0));
      tick();
      chk("tbl_done", 320'({done, pc, retire_cnt}), 320'({1'b1, tbl[i].r.pc, 64'd1}));
      chk("tbl_gpr", 320'({gpr_wen, gpr_waddr, gpr_wdata}), 320'({tbl[i].e_gwen, tbl[i].e_gaddr, tbl[i].e_gdata}));
      chk("tbl_csr", 320'({csr_wen, csr_waddr}), 320'({tbl[i].e_cwen, tbl[i].e_caddr}));
      tick();
      chk("tbl_hold", 320'({done, gpr_wen, pc, gpr_wdata}), 320'({2'b00, tbl[i].r.pc, tbl[i].e_gdata}));
    end
    // Back-pressure: 8 records offered while the output is stalled for 10 cycles.
    do_reset();
    k = 0; dbg_stall = 1; wb_valid = 1;
    for (int c = 0; c < 10; c++) begin
      drive(mk(32'h1000 + 32'(k) * 4));
      tick();
      if (last_push) k++;
    end
    chk("t2_accepted", 320'(k), 320'(4));
    chk("t2_ready_low", 320'({wb_ready, done}), 320'(0));
    dbg_stall = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      drive(mk(32'h1000 + 32'(k) * 4));
      tick();
      if (last_push) k++;
    end
    wb_valid = 0;
    for (int c = 0; c < 20 && dlog.size() < 8; c++) tick();
    chk("t2_count", 320'(dlog.size()), 320'(8));
    for (int i = 0; i < 8 && i < dlog.size(); i++)
      chk("t2_order", 320'(dlog[i].pc), 320'(32'h1000 + 32'(i) * 4));
    // CSR write followed by ebreak: halt latches and later pushes are refused.
    do_reset();
    r = mk(32'h80000004); r.cwen = 1; r.caddr = 12'h300; r.cdata = 32'h1800;
    drive(r); wb_valid = 1;
    tick();
    r = mk(32'h80000008); r.inst = 32'h00100073; r.brk = 1;
    drive(r);
    tick();
    chk("t4_halted", 320'({halted, wb_ready}), 320'(2'b10));
    drive(mk(32'h8000000c));
    for (int c = 0; c < 6; c++) tick();
    chk("t4_count", 320'(dlog.size()), 320'(2));
    if (dlog.size() == 2) begin
      chk("t4_csr", 320'({dlog[0].pc, dlog[0].cwen, dlog[0].caddr, dlog[0].brk}), 320'({32'h80000004, 1'b1, 32'h300, 1'b0}));
      chk("t4_brk", 320'({dlog[1].pc, dlog[1].brk}), 320'({32'h80000008, 1'b1}));
    end
    chk("t4_refused", 320'({halted, wb_ready, retire_cnt}), 320'({2'b10, 64'd2}));
    wb_valid = 0;
    // Reset with records queued behind a stall discards them.
    do_reset();
    dbg_stall = 1; wb_valid = 1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(32'h2000 + 32'(i) * 4));
      tick();
    end
    reset = 1; wb_valid = 0; dbg_stall = 0;
    tick();
    reset = 0;
    dlog.delete();
    for (int c = 0; c < 5; c++) tick();
    chk("t5_nostrobe", 320'(dlog.size()), 320'(0));
    chk("t5_state", 320'({pc, retire_cnt, wb_ready}), 320'({RESET_PC, 64'd0, 1'b1}));
    // Full-throughput stream of 1000 records.
    do_reset();
    k = 0; wb_valid = 1;
    for (int c = 0; c < 1100 && dlog.size() < 1000; c++) begin
      wb_valid = k < 1000;
      drive(mk(32'h10000 + 32'(k) * 4));
      tick();
      if (last_push) k++;
    end
    wb_valid = 0;
    chk("t6_count", 320'(dlog.size()), 320'(1000));
    chk("t6_cnt", 320'(retire_cnt), 320'(1000));
    begin
      int bad = 0;
      for (int i = 1; i < dlog.size(); i++) if (dlog[i].pc <= dlog[i-1].pc) bad++;
      chk("t6_increasing", 320'(bad), 320'(0));
    end
    // Random traffic against the queue model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r.pc = $urandom; r.inst = $urandom; r.gwen = 1'($urandom); r.gaddr = 5'($urandom);
      r.gdata = $urandom; r.cwen = 1'($urandom); r.caddr = 12'($urandom); r.cdata = $urandom;
      r.brk = $urandom_range(0, 99) == 0; r.ivd = $urandom_range(0, 99) == 0;
      drive(r);
      wb_valid = $urandom_range(0, 9) < 7;
      dbg_stall = $urandom_range(0, 9) < 3;
      reset = $urandom_range(0, 99) == 0;
      tick();
    end
    reset = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
